instr_mix_profiler: RTL and testbench

- Clocked, parametrised successor to the combinational instruction-class tally in the RV32 core.
- Classifies each retiring instruction by opcode into one of ten classes and keeps one counter per class, plus a total.
- Adds saturate/wrap mode, synchronous clear, sticky overflow flags, and an atomic snapshot handshake with a registered read port.
- Sits beside the writeback stage; observes only and never stalls the pipeline.

---
 rtl/instr_mix_profiler_if.sv | 27 ++
 rtl/instr_mix_profiler.sv | 135 +++++++++++++
 tb/tb_instr_mix_profiler.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/instr_mix_profiler_if.sv
// Retire-side observation bus for instr_mix_profiler: instruction stream in,
// snapshot handshake, registered read port and sticky overflow flags out.
interface instr_mix_profiler_if #(
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 17
);
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               flush;
  logic               clr;
  logic               snap_req;
  logic               snap_ack;
  logic               rd_shadow;
  logic [3:0]         rd_sel;
  logic [CNT_W-1:0]   rd_data;
  logic [11:0]        ovf;

  modport master (
    output instr_valid, instr, flush, clr, snap_req, rd_shadow, rd_sel,
    input  snap_ack, rd_data, ovf
  );

  modport slave (
    input  instr_valid, instr, flush, clr, snap_req, rd_shadow, rd_sel,
    output snap_ack, rd_data, ovf
  );
endinterface

// File: rtl/instr_mix_profiler.sv
// Per-class retired-instruction counters with live/shadow banks and registered read.
// Optional free-running cycle counter at index 11 when PROF_CYCLE_EN is defined.
module instr_mix_cnt #(
  parameter int CNT_W    = 17,
  parameter int SAT_MODE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             snap,
  input  logic             inc,
  output logic [CNT_W-1:0] live,
  output logic [CNT_W-1:0] shadow,
  output logic             ovf
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // shadow samples pre-edge live, so same-cycle clr/increment never leaks in
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live   <= '0;
      shadow <= '0;
      ovf    <= 1'b0;
    end else begin
      if (snap) shadow <= live;
      if (clr) begin
        live <= '0;
        ovf  <= 1'b0;
      end else if (inc) begin
        if (&live) begin
          ovf  <= 1'b1;
          live <= (SAT_MODE != 0) ? live : '0;
        end else begin
          live <= live + ONE;
        end
      end
    end
  end
endmodule

module instr_mix_profiler #(
  parameter int INSTR_W  = 32,
  parameter int CNT_W    = 17,
  parameter int SAT_MODE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_mix_profiler_if.slave  bus
);
  localparam int NCNT = 12;
`ifdef PROF_CYCLE_EN
  localparam int NBUILT = 12;
`else
  localparam int NBUILT = 11;
`endif

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  logic [3:0]                  cls;
  logic                        ev;
  logic [NCNT-1:0]             inc;
  logic [NCNT-1:0][CNT_W-1:0]  live;
  logic [NCNT-1:0][CNT_W-1:0]  shadow;
  logic [NCNT-1:0]             ovf_q;
  logic                        unused_instr_hi;

  assign unused_instr_hi = ^bus.instr[INSTR_W-1:7];
  assign ev = bus.instr_valid & ~bus.flush;

  always_comb begin
    cls = 4'd9;
    unique case (bus.instr[6:0])
      OP_R:     cls = 4'd0;
      OP_IALU:  cls = 4'd1;
      OP_STORE: cls = 4'd2;
      OP_LOAD:  cls = 4'd3;
      OP_BR:    cls = 4'd4;
      OP_LUI:   cls = 4'd5;
      OP_AUIPC: cls = 4'd6;
      OP_JAL:   cls = 4'd7;
      OP_JALR:  cls = 4'd8;
      default:  cls = 4'd9;
    endcase
  end

  for (genvar g = 0; g < 10; g++) begin : g_cls_inc
    assign inc[g] = ev & (cls == 4'(g));
  end
  assign inc[10] = ev;
  assign inc[11] = 1'b1;

  for (genvar g = 0; g < NBUILT; g++) begin : g_cnt
    instr_mix_cnt #(.CNT_W(CNT_W), .SAT_MODE(SAT_MODE)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (bus.clr),
      .snap   (bus.snap_req),
      .inc    (inc[g]),
      .live   (live[g]),
      .shadow (shadow[g]),
      .ovf    (ovf_q[g])
    );
  end

`ifndef PROF_CYCLE_EN
  logic unused_inc11;
  assign unused_inc11 = inc[11];
  assign live[11]     = '0;
  assign shadow[11]   = '0;
  assign ovf_q[11]    = 1'b0;
`endif

  assign bus.ovf = ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.snap_ack <= 1'b0;
      bus.rd_data  <= '0;
    end else begin
      bus.snap_ack <= bus.snap_req;
      if (bus.rd_sel < 4'd12)
        bus.rd_data <= bus.rd_shadow ? shadow[bus.rd_sel] : live[bus.rd_sel];
      else
        bus.rd_data <= '0;
    end
  end
endmodule

// File: tb/tb_instr_mix_profiler.sv
// Directed bench: one full-width saturating DUT plus two 4-bit DUTs (saturate/wrap)
// driven with identical stimulus.
module tb_instr_mix_profiler;
  localparam logic [31:0] I_R     = 32'h00B50533;
  localparam logic [31:0] I_LOAD  = 32'h0002A283;
  localparam logic [31:0] I_JALR  = 32'h00008067;
  localparam logic [31:0] I_STORE = 32'h0062A023;
  localparam logic [31:0] I_BR    = 32'h00B50463;
  localparam logic [31:0] I_LUI   = 32'h000012B7;
  localparam logic [31:0] I_ADDI  = 32'h00100093;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_mix_profiler_if #(.INSTR_W(32), .CNT_W(17)) mi ();
  instr_mix_profiler_if #(.INSTR_W(32), .CNT_W(4))  si ();
  instr_mix_profiler_if #(.INSTR_W(32), .CNT_W(4))  wi ();

  instr_mix_profiler #(.INSTR_W(32), .CNT_W(17), .SAT_MODE(1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(mi));
  instr_mix_profiler #(.INSTR_W(32), .CNT_W(4),  .SAT_MODE(1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(si));
  instr_mix_profiler #(.INSTR_W(32), .CNT_W(4),  .SAT_MODE(0)) dut_w (.clk(clk), .rst_n(rst_n), .bus(wi));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic f,
                       input logic c, input logic s);
    mi.instr_valid = v; mi.instr = w; mi.flush = f; mi.clr = c; mi.snap_req = s;
    si.instr_valid = v; si.instr = w; si.flush = f; si.clr = c; si.snap_req = s;
    wi.instr_valid = v; wi.instr = w; wi.flush = f; wi.clr = c; wi.snap_req = s;
  endtask

  task automatic sel(input logic sh, input logic [3:0] idx);
    mi.rd_shadow = sh; mi.rd_sel = idx;
    si.rd_shadow = sh; si.rd_sel = idx;
    wi.rd_shadow = sh; wi.rd_sel = idx;
  endtask

  task automatic retire(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, w, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // one idle cycle so rd_data reflects the selected register
  task automatic rd(input logic sh, input logic [3:0] idx);
    sel(sh, idx);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    sel(1'b0, 4'd0);
    rst_n = 1'b0;
    tick(); tick();
    chk("reset_rd_data", 32'(mi.rd_data), 0);
    chk("reset_ovf", 32'(mi.ovf), 0);
    chk("reset_snap_ack", 32'(mi.snap_ack), 0);
    rst_n = 1'b1;

    // 3 R, 1 load, 1 JALR
    retire(I_R, 3);
    retire(I_LOAD, 1);
    retire(I_JALR, 1);
    rd(1'b0, 4'd0);  chk("live_r", 32'(mi.rd_data), 3);
    rd(1'b0, 4'd3);  chk("live_load", 32'(mi.rd_data), 1);
    rd(1'b0, 4'd8);  chk("live_jalr", 32'(mi.rd_data), 1);
    rd(1'b0, 4'd10); chk("live_total", 32'(mi.rd_data), 5);

    // squashed and non-valid instructions are ignored
    drive(1'b1, I_JALR, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, I_JALR, 1'b0, 1'b0, 1'b0); tick();
    rd(1'b0, 4'd8);  chk("flush_jalr", 32'(mi.rd_data), 1);
    rd(1'b0, 4'd10); chk("flush_total", 32'(mi.rd_data), 5);

    // snapshot together with a counted store
    drive(1'b1, I_STORE, 1'b0, 1'b0, 1'b1); tick();
    chk("snap_ack_pulse", 32'(mi.snap_ack), 1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0); tick();
    chk("snap_ack_drop", 32'(mi.snap_ack), 0);
    rd(1'b1, 4'd10); chk("shadow_total", 32'(mi.rd_data), 5);
    rd(1'b0, 4'd10); chk("live_total_snap", 32'(mi.rd_data), 6);
    rd(1'b1, 4'd2);  chk("shadow_store", 32'(mi.rd_data), 0);
    rd(1'b0, 4'd2);  chk("live_store", 32'(mi.rd_data), 1);
    retire(I_ADDI, 2);
    rd(1'b1, 4'd10); chk("shadow_total_hold", 32'(mi.rd_data), 5);
    rd(1'b0, 4'd10); chk("live_total_more", 32'(mi.rd_data), 8);
    rd(1'b1, 4'd12); chk("shadow_sel12", 32'(mi.rd_data), 0);
    rd(1'b0, 4'd14); chk("live_sel14", 32'(mi.rd_data), 0);

    // clr beats a same-cycle branch
    drive(1'b1, I_BR, 1'b0, 1'b1, 1'b0); tick();
    chk("clr_ovf", 32'(mi.ovf), 0);
    rd(1'b0, 4'd4);  chk("clr_branch", 32'(mi.rd_data), 0);
    rd(1'b0, 4'd10); chk("clr_total", 32'(mi.rd_data), 0);

    // clr with snap_req keeps pre-clear values in the shadow
    retire(I_LUI, 2);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1); tick();
    rd(1'b1, 4'd5);  chk("clrsnap_shadow_lui", 32'(mi.rd_data), 2);
    rd(1'b1, 4'd10); chk("clrsnap_shadow_total", 32'(mi.rd_data), 2);
    rd(1'b0, 4'd10); chk("clrsnap_live_total", 32'(mi.rd_data), 0);

    // overflow on the 4-bit instances
    retire(I_ADDI, 17);
    rd(1'b0, 4'd1);
    chk("ovf_main_cnt", 32'(mi.rd_data), 17);
    chk("ovf_sat_cnt", 32'(si.rd_data), 15);
    chk("ovf_wrap_cnt", 32'(wi.rd_data), 1);
    chk("ovf_sat_flag", 32'(si.ovf[1]), 1);
    chk("ovf_wrap_flag", 32'(wi.ovf[1]), 1);
    chk("ovf_main_flag", 32'(mi.ovf[1]), 0);
    rd(1'b0, 4'd10);
    chk("ovf_wrap_total", 32'(wi.rd_data), 1);
    chk("ovf_sat_total", 32'(si.rd_data), 15);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0); tick();
    chk("ovf_clr_sat", 32'(si.ovf), 0);
    chk("ovf_clr_wrap", 32'(wi.ovf), 0);
    rd(1'b0, 4'd1);
    chk("ovf_clr_sat_cnt", 32'(si.rd_data), 0);
    chk("ovf_clr_wrap_cnt", 32'(wi.rd_data), 0);

    // reset mid-stream
    retire(I_ADDI, 16);
    chk("pre_rst_sat_ovf", 32'(si.ovf[1]), 1);
    rd(1'b1, 4'd10); chk("pre_rst_shadow", 32'(mi.rd_data), 2);
    drive(1'b1, I_R, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_rd_data", 32'(mi.rd_data), 0);
    chk("rst_ovf_main", 32'(mi.ovf), 0);
    chk("rst_ovf_sat", 32'(si.ovf), 0);
    chk("rst_snap_ack", 32'(mi.snap_ack), 0);
    rd(1'b1, 4'd10); chk("rst_shadow_total", 32'(mi.rd_data), 0);
    rd(1'b0, 4'd1);  chk("rst_live_addi", 32'(mi.rd_data), 0);

    // cycle counter 20 cycles after reset
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sel(1'b0, 4'd11);
    repeat (20) tick();
`ifdef PROF_CYCLE_EN
    checks++;
    assert (mi.rd_data >= 17'd19 && mi.rd_data <= 17'd21) else begin
      errors++;
      $error("FAIL cycle_cnt: observed %0d expected 19..21", mi.rd_data);
    end
`else
    chk("cycle_cnt_off", 32'(mi.rd_data), 0);
    chk("cycle_ovf_off", 32'(mi.ovf[11]), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
